// File: rtl/mac_timestep_scheduler.sv
// Purpose: sequences one MAC unit. It holds mac_set during the init phase, round-robin
//          arbitrates spike source addresses onto the MAC address input, and frames
//          fixed-length timesteps (RUN, DRAIN, CLEAR) ending in a one-cycle clear.
// Latency: req_ready is combinational in RUN. mac_src_addr/valid follow the grant by 1 cycle.
// Backpressure: requesters that are not granted hold valid/addr. Nothing is dropped.
//          No grants are issued outside RUN.
// Ports: CLK/RST_N (async active-low) | start/stop pulses | req_valid/req_addr/req_ready
//        (one-hot grant) | mac_set, mac_clear, mac_src_addr, mac_src_valid | timestep_done,
//        timestep_idx, busy | spike_count (SPIKE_COUNT_EN only).
// Option: define SPIKE_COUNT_EN to add the saturating per-timestep grant count output.
module mac_timestep_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 12,
  parameter int TS_CYCLES   = 4,
  parameter int INIT_CYCLES = 2,
  parameter int TS_IDX_W    = 16
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      start,
  input  logic                      stop,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      mac_set,
  output logic                      mac_clear,
  output logic [ADDR_W-1:0]         mac_src_addr,
  output logic                      mac_src_valid,
  output logic                      timestep_done,
  output logic [TS_IDX_W-1:0]       timestep_idx,
  output logic                      busy
`ifdef SPIKE_COUNT_EN
  ,
  output logic [ADDR_W-1:0]         spike_count
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MAX_C = (INIT_CYCLES > TS_CYCLES) ? INIT_CYCLES : TS_CYCLES;
  localparam int CNT_W = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_DRAIN, S_CLEAR} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                stop_q, stop_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]   src_addr_q, src_addr_d;
  logic                src_vld_q, src_vld_d;
  logic [TS_IDX_W-1:0] ts_idx_q, ts_idx_d;

  logic [NUM_REQ-1:0]  grant;
  logic [PTR_W-1:0]    grant_idx;
  logic                grant_any;
  int                  arb_idx;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. cnt_q times both INIT and RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) state_d = S_INIT;
      end
      S_INIT: begin
        if (cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_W'(TS_CYCLES - 3)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: state_d = S_CLEAR;
      // A stop arriving in CLEAR itself still ends the run here.
      S_CLEAR: state_d = (stop_q || stop) ? S_IDLE : S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Round-robin arbiter. The search starts at rr_ptr_q and grants only in RUN.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    arb_idx   = 0;
    if (state_q == S_RUN) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        arb_idx = int'(rr_ptr_q) + k;
        if (arb_idx >= NUM_REQ) arb_idx = arb_idx - NUM_REQ;
        if (!grant_any && req_valid[arb_idx]) begin
          grant_any      = 1'b1;
          grant[arb_idx] = 1'b1;
          grant_idx      = PTR_W'(arb_idx);
        end
      end
    end
  end

  // Output decode
  always_comb begin
    req_ready     = grant;
    mac_set       = (state_q == S_INIT);
    mac_clear     = (state_q == S_CLEAR);
    timestep_done = (state_q == S_CLEAR);
    busy          = (state_q != S_IDLE);
    mac_src_addr  = src_addr_q;
    mac_src_valid = src_vld_q;
    timestep_idx  = ts_idx_q;
  end

  // Datapath next-state
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    src_vld_d  = grant_any;
    src_addr_d = src_addr_q;
    ts_idx_d   = ts_idx_q;
    stop_d     = stop_q;
    if (grant_any) begin
      src_addr_d = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
      rr_ptr_d   = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + PTR_W'(1);
    end
    if (state_q == S_CLEAR) ts_idx_d = ts_idx_q + TS_IDX_W'(1);
    // A stop seen in IDLE counts only when start arrives in the same cycle.
    if (state_q == S_IDLE)       stop_d = start && stop;
    else if (state_q == S_CLEAR) stop_d = 1'b0;
    else                         stop_d = stop_q || stop;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rr_ptr_q   <= '0;
      src_vld_q  <= 1'b0;
      src_addr_q <= '0;
      ts_idx_q   <= '0;
      stop_q     <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      src_vld_q  <= src_vld_d;
      src_addr_q <= src_addr_d;
      ts_idx_q   <= ts_idx_d;
      stop_q     <= stop_d;
    end
  end

`ifdef SPIKE_COUNT_EN
  logic [ADDR_W-1:0] grant_cnt_q, grant_cnt_d;
  logic [ADDR_W-1:0] spike_cnt_q, spike_cnt_d;

  // No grants happen in DRAIN/CLEAR, so the count is final when CLEAR is reached.
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    spike_cnt_d = spike_cnt_q;
    if (state_q == S_CLEAR) begin
      spike_cnt_d = grant_cnt_q;
      grant_cnt_d = '0;
    end else if (grant_any && (grant_cnt_q != '1)) begin
      grant_cnt_d = grant_cnt_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      grant_cnt_q <= '0;
      spike_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      spike_cnt_q <= spike_cnt_d;
    end
  end

  assign spike_count = spike_cnt_q;
`endif

endmodule
